riscq_mem_loader: RTL and testbench
===================================

# riscq_mem_loader

Byte-stream boot loader sitting directly upstream of `riscq_soc`. It decodes framed commands from a host byte link (UART RX or host FIFO) and drives the SoC's instruction-ROM and data-RAM initialisation write ports. Once loading finishes, it raises both `init_done` strobes and then releases the CPU reset. It replaces the bench-driven initialisation sequence in hardware builds.

## Interface
- `ADDR_W`, 12: word-address width of both memory init ports.
- `RST_DLY`, 2: cycles between `init_done` rising and CPU reset release (range 1..15).
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_rx_data` in 8: host byte.
- `i_rx_valid` in 1: byte valid. A byte is accepted on a rising edge with `i_rx_valid && o_rx_ready`.
- `o_rx_ready` out 1: loader can accept a byte.
- `o_inst_waddr` out ADDR_W, `o_inst_wdata` out 32, `o_inst_we` out 1: instruction-ROM init write port.
- `o_inst_init_done` out 1: instruction-ROM init complete.
- `o_data_waddr` out ADDR_W, `o_data_wdata` out 32, `o_data_we` out 1: data-RAM init write port.
- `o_data_init_done` out 1: data-RAM init complete.
- `o_cpu_rst` out 1: active-high reset to `riscq_soc`.
- `o_err` out 1: sticky error flag.
- `o_err_code` out 2: error code. 01 = bad command, 10 = checksum fail.

## Operation
- **Commands** (first byte of each frame):
  - 0x01: load instruction ROM.
  - 0x02: load data RAM.
  - 0x03: run.
  - 0x04: halt.
- **Load frame:** CMD, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then CNT words as 4 bytes each (little-endian), then CSUM.
  - Start address is {ADDR_HI, ADDR_LO}[ADDR_W-1:0]; upper bits are ignored.
  - CNT = 0 means no data bytes; CSUM follows CNT_HI directly.
  - The 8-bit sum of all frame bytes, CMD through CSUM inclusive, must be 0x00.
- **States:** IDLE, HDR (4 bytes, counted), WORD (2-bit byte index), CSUM, CHECK, ARM.
  - IDLE: on command 0x01/0x02 → HDR. On 0x03 → ARM if `o_err`=0, otherwise stay in IDLE. On 0x04 → IDLE. Any other byte → IDLE with `o_err`=1, code 01.
  - HDR → WORD if CNT≠0, otherwise → CSUM.
  - WORD: after byte index 3, write one word, increment the address, decrement the remaining count. Go to CSUM when the count reaches 0.
  - CSUM → CHECK.
  - CHECK (1 cycle) → IDLE. If the sum ≠ 0, set `o_err`=1 with code 10.
  - ARM: count RST_DLY cycles → IDLE with `o_cpu_rst`=0.
- **Word write:** target port follows the frame's CMD. Address wraps from 2^ADDR_W−1 to 0.
- **Checksum failure:** words already written stay written. Run (0x03) is ignored while `o_err`=1.
- **Halt (0x04):**
  - Clears `o_err` and `o_err_code`.
  - Sets `o_cpu_rst`=1.
  - Clears both `init_done` outputs.
  - If received in ARM, ARM is aborted.
- **Load while running:** a 0x01/0x02 command with `o_cpu_rst`=0 first performs an implicit halt (reset=1, `init_done`=0, error not cleared), then loads normally.
- **Reset mid-frame:** the frame is discarded and all outputs return to reset values.

## Timing
- **Reset values:**
  - `o_cpu_rst`=1.
  - All other outputs 0, including `o_rx_ready`.
  - `o_rx_ready` rises on the first edge after `i_rst_n` deasserts.
- **`o_rx_ready`:** 1 in every state except CHECK and ARM. Maximum throughput is 1 byte/cycle with no bubbles inside a frame.
- **Word write:** `o_*_we` is a registered pulse of exactly 1 cycle, asserted the cycle after the 4th data byte is accepted. Address and data are valid in the same cycle and held until the next write.
- **CHECK:** occupies the cycle after CSUM is accepted. The error flag updates at the end of CHECK.
- **Run:**
  - Both `o_*_init_done` go to 1 the cycle after the 0x03 byte is accepted.
  - `o_cpu_rst` falls RST_DLY cycles later.
- **Halt:** takes effect the cycle after the 0x04 byte is accepted.
- **Simultaneous events:** accepted bytes are decoded in order. No two writes share a cycle.

## Structure
- Package `riscq_loader_pkg` holds:
  - Command byte constants.
  - State enum.
  - Error code constants.
  - Default RST_DLY.
- One sub-module is natural: `riscq_loader_word_asm`. It takes byte in, valid and clear, and produces a 32-bit little-endian word plus a word-done strobe.
- The FSM, address/count counters, checksum accumulator and release counter stay in the top module.

## Test plan
- Inst frame 01 00 00 01 00 EF BE AD DE C6 → one `o_inst_we` pulse with addr 0x000, data 0xDEADBEEF. `o_err`=0.
- Data frame at addr 0xFFF, CNT=2, words 0x11111111 and 0x22222222, correct CSUM → writes at 0xFFF then 0x000. `o_inst_we` never asserts.
- The frame from the first scenario with CSUM 0xC7 → word still written. `o_err`=1, `o_err_code`=10. A following 0x03 leaves `o_cpu_rst`=1. Then 0x04 clears the error, and a subsequent 0x03 runs.
- 0x03 after a good load → both `init_done`=1 one cycle after acceptance. `o_cpu_rst` falls 2 cycles after that. `o_rx_ready`=0 during ARM.
- Byte 0x7F in IDLE → `o_err`=1, code 01, no writes. 0x01 frame while running → `o_cpu_rst` rises and `init_done` falls before the first write.
- `i_rst_n` pulsed low mid-WORD → all outputs return to reset values immediately. A new full frame afterwards loads correctly.

Source files
------------

// File: rtl/riscq_loader_pkg.sv
// Shared constants and state encoding for the riscq byte-stream boot loader.
package riscq_loader_pkg;

  localparam logic [7:0] CMD_LOAD_INST = 8'h01;
  localparam logic [7:0] CMD_LOAD_DATA = 8'h02;
  localparam logic [7:0] CMD_RUN       = 8'h03;
  localparam logic [7:0] CMD_HALT      = 8'h04;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_CMD = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;

  localparam int RST_DLY_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WORD,
    ST_CSUM,
    ST_CHECK,
    ST_ARM
  } ld_state_e;

endpackage

// File: rtl/riscq_loader_word_asm.sv
// Collects four payload bytes into a little-endian word; done fires with the 4th byte.
module riscq_loader_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        valid,
  input  logic        clear,
  output logic [31:0] word,
  output logic        done
);

  logic [1:0]  idx;
  logic [23:0] lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
      lo  <= 24'd0;
    end else if (clear) begin
      idx <= 2'd0;
    end else if (valid) begin
      idx <= idx + 2'd1;
      case (idx)
        2'd0:    lo[7:0]   <= byte_in;
        2'd1:    lo[15:8]  <= byte_in;
        2'd2:    lo[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  // The top byte is taken straight from the input so the word is complete on the accept edge.
  assign word = {byte_in, lo};
  assign done = valid && !clear && (idx == 2'd3);

endmodule

// File: rtl/riscq_mem_loader.sv
// Boot loader: decodes framed host commands into ROM/RAM init writes, then sequences CPU reset release.
//   state | meaning
//   IDLE  | waiting for a command byte
//   HDR   | collecting ADDR_LO, ADDR_HI, CNT_LO, CNT_HI
//   WORD  | collecting payload bytes, one write per 4 bytes
//   CSUM  | waiting for the checksum byte
//   CHECK | one cycle to judge the frame sum, rx not ready
//   ARM   | counting down to CPU reset release, rx not ready
module riscq_mem_loader
  import riscq_loader_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int RST_DLY = RST_DLY_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic [ADDR_W-1:0] o_inst_waddr,
  output logic [31:0]       o_inst_wdata,
  output logic              o_inst_we,
  output logic              o_inst_init_done,
  output logic [ADDR_W-1:0] o_data_waddr,
  output logic [31:0]       o_data_wdata,
  output logic              o_data_we,
  output logic              o_data_init_done,
  output logic              o_cpu_rst,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  ld_state_e         state;
  logic [1:0]        hdr_idx;
  logic [7:0]        hdr_lo;
  logic [7:0]        sum;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       cnt;
  logic              to_inst;
  logic [3:0]        arm_cnt;

  logic        acc;
  logic [15:0] hdr_word;
  logic [31:0] asm_word;
  logic        asm_done;

  assign acc      = i_rx_valid && o_rx_ready;
  assign hdr_word = {i_rx_data, hdr_lo};

  riscq_loader_word_asm u_word_asm (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .byte_in (i_rx_data),
    .valid   (acc && (state == ST_WORD)),
    .clear   (state != ST_WORD),
    .word    (asm_word),
    .done    (asm_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= ST_IDLE;
      hdr_idx          <= 2'd0;
      hdr_lo           <= 8'd0;
      sum              <= 8'd0;
      addr             <= '0;
      cnt              <= 16'd0;
      to_inst          <= 1'b0;
      arm_cnt          <= 4'd0;
      o_rx_ready       <= 1'b0;
      o_inst_waddr     <= '0;
      o_inst_wdata     <= 32'd0;
      o_inst_we        <= 1'b0;
      o_inst_init_done <= 1'b0;
      o_data_waddr     <= '0;
      o_data_wdata     <= 32'd0;
      o_data_we        <= 1'b0;
      o_data_init_done <= 1'b0;
      o_cpu_rst        <= 1'b1;
      o_err            <= 1'b0;
      o_err_code       <= ERR_NONE;
    end else begin
      o_inst_we  <= 1'b0;
      o_data_we  <= 1'b0;
      o_rx_ready <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (acc) begin
            case (i_rx_data)
              CMD_LOAD_INST, CMD_LOAD_DATA: begin
                to_inst <= (i_rx_data == CMD_LOAD_INST);
                sum     <= i_rx_data;
                hdr_idx <= 2'd0;
                state   <= ST_HDR;
                // Implicit halt; a no-op when the CPU is already held in reset.
                o_cpu_rst        <= 1'b1;
                o_inst_init_done <= 1'b0;
                o_data_init_done <= 1'b0;
              end
              CMD_RUN: begin
                if (!o_err) begin
                  state            <= ST_ARM;
                  arm_cnt          <= 4'(RST_DLY - 1);
                  o_rx_ready       <= 1'b0;
                  o_inst_init_done <= 1'b1;
                  o_data_init_done <= 1'b1;
                end
              end
              CMD_HALT: begin
                o_err            <= 1'b0;
                o_err_code       <= ERR_NONE;
                o_cpu_rst        <= 1'b1;
                o_inst_init_done <= 1'b0;
                o_data_init_done <= 1'b0;
              end
              default: begin
                o_err      <= 1'b1;
                o_err_code <= ERR_BAD_CMD;
              end
            endcase
          end
        end
        ST_HDR: begin
          if (acc) begin
            sum     <= sum + i_rx_data;
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0: hdr_lo <= i_rx_data;
              2'd1: addr   <= hdr_word[ADDR_W-1:0];
              2'd2: hdr_lo <= i_rx_data;
              default: begin
                cnt   <= hdr_word;
                state <= (hdr_word == 16'd0) ? ST_CSUM : ST_WORD;
              end
            endcase
          end
        end
        ST_WORD: begin
          if (acc) begin
            sum <= sum + i_rx_data;
            if (asm_done) begin
              if (to_inst) begin
                o_inst_we    <= 1'b1;
                o_inst_waddr <= addr;
                o_inst_wdata <= asm_word;
              end else begin
                o_data_we    <= 1'b1;
                o_data_waddr <= addr;
                o_data_wdata <= asm_word;
              end
              addr <= addr + ADDR_W'(1);
              cnt  <= cnt - 16'd1;
              if (cnt == 16'd1) state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (acc) begin
            sum        <= sum + i_rx_data;
            state      <= ST_CHECK;
            o_rx_ready <= 1'b0;
          end
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          if (sum != 8'd0) begin
            o_err      <= 1'b1;
            o_err_code <= ERR_CSUM;
          end
        end
        ST_ARM: begin
          if (arm_cnt == 4'd0) begin
            state     <= ST_IDLE;
            o_cpu_rst <= 1'b0;
          end else begin
            arm_cnt    <= arm_cnt - 4'd1;
            o_rx_ready <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscq_mem_loader.sv
// Self-checking bench for riscq_mem_loader: directed scenarios, then random command streams vs a frame-level model.
module tb_riscq_mem_loader;

  localparam int ADDR_W  = 12;
  localparam int RST_DLY = 2;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [7:0]        i_rx_data = 8'd0;
  logic              i_rx_valid = 1'b0;
  logic              o_rx_ready;
  logic [ADDR_W-1:0] o_inst_waddr;
  logic [31:0]       o_inst_wdata;
  logic              o_inst_we;
  logic              o_inst_init_done;
  logic [ADDR_W-1:0] o_data_waddr;
  logic [31:0]       o_data_wdata;
  logic              o_data_we;
  logic              o_data_init_done;
  logic              o_cpu_rst;
  logic              o_err;
  logic [1:0]        o_err_code;

  riscq_mem_loader #(.ADDR_W(ADDR_W), .RST_DLY(RST_DLY)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_rx_data        (i_rx_data),
    .i_rx_valid       (i_rx_valid),
    .o_rx_ready       (o_rx_ready),
    .o_inst_waddr     (o_inst_waddr),
    .o_inst_wdata     (o_inst_wdata),
    .o_inst_we        (o_inst_we),
    .o_inst_init_done (o_inst_init_done),
    .o_data_waddr     (o_data_waddr),
    .o_data_wdata     (o_data_wdata),
    .o_data_we        (o_data_we),
    .o_data_init_done (o_data_init_done),
    .o_cpu_rst        (o_cpu_rst),
    .o_err            (o_err),
    .o_err_code       (o_err_code)
  );

  always #5 i_clk = ~i_clk;

  // port bit: 1 = instruction ROM, 0 = data RAM
  typedef struct packed {
    logic              port;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  dbl_we = 0;
  logic prev_we = 1'b0;
  bit   gaps = 1'b0;

  logic       m_err = 1'b0;
  logic [1:0] m_code = 2'b00;
  logic       m_rst = 1'b1;
  logic       m_done = 1'b0;

  logic [31:0] wbuf [8];
  logic [7:0]  frame1 [10];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  always @(negedge i_clk) begin
    if (o_inst_we) obs_q.push_back({1'b1, o_inst_waddr, o_inst_wdata});
    if (o_data_we) obs_q.push_back({1'b0, o_data_waddr, o_data_wdata});
    if ((o_inst_we || o_data_we) && prev_we) dbl_we++;
    if (o_inst_we && o_data_we) dbl_we++;
    prev_we = o_inst_we || o_data_we;
  end

  // Called at a falling edge; returns at the falling edge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      i_rx_valid = 1'b0;
      @(negedge i_clk);
    end
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (!o_rx_ready && n < 64) begin
      @(negedge i_clk);
      n++;
    end
    if (n == 64) chk("rx_ready_timeout", 64'(o_rx_ready), 64'd1);
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_load(input bit inst, input logic [15:0] a16, input int cnt,
                           input logic [7:0] csum_xor);
    logic [7:0] fb[$];
    logic [7:0] s = 8'd0;
    bit was_run = !m_rst;
    fb.push_back(inst ? 8'h01 : 8'h02);
    fb.push_back(a16[7:0]);
    fb.push_back(a16[15:8]);
    fb.push_back(8'(cnt));
    fb.push_back(8'(cnt >> 8));
    for (int i = 0; i < cnt; i++)
      for (int k = 0; k < 4; k++) fb.push_back(8'(wbuf[i] >> (8 * k)));
    foreach (fb[i]) s = s + fb[i];
    fb.push_back((8'h00 - s) ^ csum_xor);
    m_rst  = 1'b1;
    m_done = 1'b0;
    for (int i = 0; i < cnt; i++)
      exp_q.push_back({inst, ADDR_W'((int'(a16) + i) % (1 << ADDR_W)), wbuf[i]});
    if (csum_xor != 8'd0) begin
      m_err  = 1'b1;
      m_code = 2'b10;
    end
    foreach (fb[i]) begin
      send_byte(fb[i]);
      if (i == 0 && was_run) begin
        chk("impl_halt_rst", 64'(o_cpu_rst), 64'd1);
        chk("impl_halt_done", 64'({o_inst_init_done, o_data_init_done}), 64'd0);
        chk("impl_halt_nowr", 64'(obs_q.size()), 64'd0);
      end
    end
  endtask

  task automatic send_run();
    if (!m_err) begin
      m_done = 1'b1;
      m_rst  = 1'b0;
    end
    send_byte(8'h03);
  endtask

  task automatic send_halt();
    m_err  = 1'b0;
    m_code = 2'b00;
    m_rst  = 1'b1;
    m_done = 1'b0;
    send_byte(8'h04);
  endtask

  task automatic send_bad(input logic [7:0] b);
    m_err  = 1'b1;
    m_code = 2'b01;
    send_byte(b);
  endtask

  task automatic settle(input string tag);
    repeat (RST_DLY + 3) @(negedge i_clk);
    chk({tag, "_err"}, 64'(o_err), 64'(m_err));
    chk({tag, "_code"}, 64'(o_err_code), 64'(m_code));
    chk({tag, "_cpu_rst"}, 64'(o_cpu_rst), 64'(m_rst));
    chk({tag, "_inst_done"}, 64'(o_inst_init_done), 64'(m_done));
    chk({tag, "_data_done"}, 64'(o_data_init_done), 64'(m_done));
    chk({tag, "_rdy"}, 64'(o_rx_ready), 64'd1);
    chk({tag, "_wr_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk({tag, "_wr"}, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_rdy"}, 64'(o_rx_ready), 64'd0);
    chk({tag, "_we"}, 64'({o_inst_we, o_data_we}), 64'd0);
    chk({tag, "_waddr"}, 64'({o_inst_waddr, o_data_waddr}), 64'd0);
    chk({tag, "_wdata"}, {o_inst_wdata, o_data_wdata}, 64'd0);
    chk({tag, "_done"}, 64'({o_inst_init_done, o_data_init_done}), 64'd0);
    chk({tag, "_cpu_rst"}, 64'(o_cpu_rst), 64'd1);
    chk({tag, "_err"}, 64'({o_err, o_err_code}), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge i_clk);
    check_reset_outs("rst");
    i_rst_n = 1'b1;
    #1 chk("rdy_before_edge", 64'(o_rx_ready), 64'd0);
    @(negedge i_clk);
    chk("rdy_after_rst", 64'(o_rx_ready), 64'd1);

    // Literal frame: one word 0xDEADBEEF at 0x000
    frame1 = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC6};
    exp_q.push_back({1'b1, 12'h000, 32'hDEADBEEF});
    for (int i = 0; i < 10; i++) begin
      send_byte(frame1[i]);
      if (i == 8) begin
        chk("we_pulse_inst", 64'(o_inst_we), 64'd1);
        chk("we_pulse_data", 64'(o_data_we), 64'd0);
      end
      if (i == 9) begin
        chk("we_single_cycle", 64'(o_inst_we), 64'd0);
        chk("rdy_in_check", 64'(o_rx_ready), 64'd0);
      end
    end
    settle("inst1");

    wbuf[0] = 32'h11111111;
    wbuf[1] = 32'h22222222;
    send_load(1'b0, 16'h0FFF, 2, 8'h00);
    settle("data_wrap");

    wbuf[0] = 32'hDEADBEEF;
    send_load(1'b1, 16'h0000, 1, 8'h01);
    settle("bad_csum");
    send_run();
    settle("run_blocked");
    send_halt();
    settle("halt_clr");

    wbuf[0] = 32'hCAFEF00D;
    wbuf[1] = 32'h0BADC0DE;
    send_load(1'b1, 16'h0010, 2, 8'h00);
    settle("good_load");
    // RST_DLY = 2: reset held for two cycles after init_done rises
    m_done = 1'b1;
    m_rst  = 1'b0;
    send_byte(8'h03);
    chk("run_inst_done", 64'(o_inst_init_done), 64'd1);
    chk("run_data_done", 64'(o_data_init_done), 64'd1);
    chk("run_rst_held0", 64'(o_cpu_rst), 64'd1);
    chk("arm_rdy0", 64'(o_rx_ready), 64'd0);
    @(negedge i_clk);
    chk("run_rst_held1", 64'(o_cpu_rst), 64'd1);
    chk("arm_rdy1", 64'(o_rx_ready), 64'd0);
    @(negedge i_clk);
    chk("run_rst_release", 64'(o_cpu_rst), 64'd0);
    chk("arm_rdy_back", 64'(o_rx_ready), 64'd1);
    settle("run");

    send_bad(8'h7F);
    settle("bad_cmd");
    wbuf[0] = 32'h12345678;
    send_load(1'b1, 16'h0200, 1, 8'h00);
    settle("load_while_run");
    send_halt();
    settle("halt2");

    // Reset pulse in the middle of a word
    send_byte(8'h01);
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    i_rst_n = 1'b0;
    #1 check_reset_outs("mid_rst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    m_err  = 1'b0;
    m_code = 2'b00;
    m_rst  = 1'b1;
    m_done = 1'b0;
    @(negedge i_clk);
    wbuf[0] = 32'hA5A5_0001;
    wbuf[1] = 32'h5A5A_0002;
    wbuf[2] = 32'hFFFF_0003;
    send_load(1'b0, 16'h0123, 3, 8'h00);
    settle("after_rst");

    gaps = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int r = $urandom_range(0, 8);
      if (r <= 4) begin
        logic [15:0] a16 = 16'($urandom);
        int cnt = $urandom_range(0, 4);
        logic [7:0] x = 8'h00;
        if ($urandom_range(0, 2) == 0) a16[11:0] = 12'hFFC | 12'($urandom_range(0, 3));
        for (int i = 0; i < cnt; i++) wbuf[i] = $urandom;
        if ($urandom_range(0, 4) == 0) x = 8'($urandom_range(1, 255));
        send_load(1'($urandom_range(0, 1)), a16, cnt, x);
      end else if (r <= 6) begin
        send_run();
      end else if (r == 7) begin
        send_halt();
      end else begin
        send_bad(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(5, 255)));
      end
      settle("rand");
    end

    chk("we_pulse_overlap", 64'(dbl_we), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
